regfile_access_sequencer: RTL and testbench
===========================================

REGFILE_ACCESS_SEQUENCER -- requirements
Module: regfile_access_sequencer

Interface
REQ-001 Parameter: XLEN, default 64, data width of register file and request/response data.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_rs1  input  5  first source register index.
REQ-007 req_rs2  input  5  second source register index.
REQ-008 req_rd  input  5  destination register index.
REQ-009 req_rd_we  input  1  destination write requested.
REQ-010 req_wr_data  input  XLEN  destination write data.
REQ-011 rsp_valid  output  1  response data valid.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_rs1_data  output  XLEN  value read from rs1.
REQ-014 rsp_rs2_data  output  XLEN  value read from rs2.
REQ-015 rf_cs  output  1  register file chip select.
REQ-016 rf_we  output  1  register file write enable.
REQ-017 rf_addr  output  5  register file address.
REQ-018 rf_wr_data  output  XLEN  register file write data.
REQ-019 rf_rd_data  input  XLEN  register file read data, combinational from rf_addr in the same cycle.

Function
REQ-020 FSM states: IDLE, RD1, RD2, WR, RSP; exactly one state active.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-022 On accept: capture rs1, rs2, rd, rd_we, wr_data into internal registers; next state RD1.
REQ-023 RD1: rf_cs=1, rf_we=0, rf_addr=captured rs1; rf_rd_data latched into rsp_rs1_data at cycle end.
REQ-024 RD1 -> RD2 when rs2 != rs1; RD1 -> WR/RSP when rs2 == rs1, with rsp_rs2_data loaded from the same rf_rd_data sample.
REQ-025 RD2: rf_cs=1, rf_we=0, rf_addr=captured rs2; rf_rd_data latched into rsp_rs2_data.
REQ-026 After reads: go to WR if rd_we=1 and rd != 0, else go directly to RSP.
REQ-027 WR: rf_cs=1, rf_we=1, rf_addr=captured rd, rf_wr_data=captured wr_data, for exactly one cycle; next RSP.
REQ-028 Reads always precede the write; read data SHALL reflect register contents before this request's write (rd == rs1 or rd == rs2 returns the old value).
REQ-029 RSP: rsp_valid=1; rsp data held stable until rsp_valid & rsp_ready on a rising edge, then IDLE.
REQ-030 Outside RD1/RD2/WR: rf_cs=0, rf_we=0, rf_addr=0, rf_wr_data=0.
REQ-031 rf_we SHALL never be 1 while rf_cs=0; at most one rf access per cycle.
REQ-032 Latency from accept edge to rsp_valid: 3 cycles (two reads, write), 2 cycles (two reads, no write, or one read plus write), 1 cycle (one read, no write).
REQ-033 Back-to-back: after RSP handshake, req_ready=1 in the next cycle; no request accepted in the RSP cycle.
REQ-034 Request inputs are ignored outside IDLE; changes to them after accept do not affect the transaction.
REQ-035 rs index 0 is read normally (register file returns 0); rd=0 write is suppressed.

Reset
REQ-036 rst=1 forces IDLE immediately and asynchronously, including mid-transaction; in-flight transaction is dropped and a pending WR is not performed after reset release.
REQ-037 Reset values: req_ready=1 (after release), rsp_valid=0, rsp_rs1_data=0, rsp_rs2_data=0, rf_cs=0, rf_we=0, rf_addr=0, rf_wr_data=0, captured request registers 0.

Verification
REQ-038 Preload x5=0x11, x6=0x22; request rs1=5, rs2=6, rd=7, rd_we=1, wr_data=0xAA -> RD1 addr 5, RD2 addr 6, WR addr 7 data 0xAA; rsp_valid 3 cycles after accept with 0x11/0x22; x7 reads back 0xAA.
REQ-039 Request rs1=rs2=5, rd_we=0 -> single read cycle, rf_we never 1, rsp_valid 1 cycle after accept with both data 0x11.
REQ-040 x5=0x11; request rs1=5, rs2=6, rd=5, rd_we=1, wr_data=0x99 -> rsp_rs1_data=0x11 (old value), later read of x5 = 0x99.
REQ-041 Request rd=0, rd_we=1, wr_data=0xFF -> no WR cycle, x0 reads 0; rsp_rs*_data for rs=0 equal 0.
REQ-042 Hold rsp_ready=0 for 5 cycles in RSP -> rsp_valid and data stable, req_ready=0, rf_cs=0 throughout; release -> IDLE next cycle.
REQ-043 Assert rst asynchronously during RD2 of a write request -> rf_cs/rf_we drop to 0 without clock edge, rsp_valid=0, target rd unchanged.

Source files
------------

// File: rtl/regfile_access_sequencer.sv
// Sequences one request into register-file reads and an optional write, then
// holds the read results on a valid/ready response port.
module regfile_access_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            req_rd_we,
    input  logic [XLEN-1:0] req_wr_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rs1_data,
    output logic [XLEN-1:0] rsp_rs2_data,
    output logic            rf_cs,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wr_data,
    input  logic [XLEN-1:0] rf_rd_data
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RSP} state_t;

    state_t          state;
    logic [4:0]      cap_rs1;
    logic [4:0]      cap_rs2;
    logic [4:0]      cap_rd;
    logic            cap_rd_we;
    logic [XLEN-1:0] cap_wr_data;
    logic            do_write;

    // Writes to x0 are dropped entirely, so no WR cycle is spent on them.
    assign do_write = cap_rd_we && (cap_rd != 5'd0);

    // Register-file strobes are registered and set up on the edge entering
    // each access state, so they align exactly with RD1/RD2/WR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
            rf_cs        <= 1'b0;
            rf_we        <= 1'b0;
            rf_addr      <= 5'd0;
            rf_wr_data   <= '0;
            cap_rs1      <= 5'd0;
            cap_rs2      <= 5'd0;
            cap_rd       <= 5'd0;
            cap_rd_we    <= 1'b0;
            cap_wr_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_rs1     <= req_rs1;
                        cap_rs2     <= req_rs2;
                        cap_rd      <= req_rd;
                        cap_rd_we   <= req_rd_we;
                        cap_wr_data <= req_wr_data;
                        req_ready   <= 1'b0;
                        rf_cs       <= 1'b1;
                        rf_we       <= 1'b0;
                        rf_addr     <= req_rs1;
                        state       <= RD1;
                    end
                end
                RD1: begin
                    rsp_rs1_data <= rf_rd_data;
                    if (cap_rs2 != cap_rs1) begin
                        rf_addr <= cap_rs2;
                        state   <= RD2;
                    end else begin
                        // Same source twice: one sample serves both operands.
                        rsp_rs2_data <= rf_rd_data;
                        if (do_write) begin
                            rf_we      <= 1'b1;
                            rf_addr    <= cap_rd;
                            rf_wr_data <= cap_wr_data;
                            state      <= WR;
                        end else begin
                            rf_cs     <= 1'b0;
                            rf_addr   <= 5'd0;
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end
                    end
                end
                RD2: begin
                    rsp_rs2_data <= rf_rd_data;
                    if (do_write) begin
                        rf_we      <= 1'b1;
                        rf_addr    <= cap_rd;
                        rf_wr_data <= cap_wr_data;
                        state      <= WR;
                    end else begin
                        rf_cs     <= 1'b0;
                        rf_addr   <= 5'd0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                WR: begin
                    rf_cs      <= 1'b0;
                    rf_we      <= 1'b0;
                    rf_addr    <= 5'd0;
                    rf_wr_data <= '0;
                    rsp_valid  <= 1'b1;
                    state      <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rf_cs     <= 1'b0;
                    rf_we     <= 1'b0;
                    rf_addr   <= 5'd0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for regfile_access_sequencer with a behavioural 32-entry
// register file that answers reads combinationally.
module tb_regfile_access_sequencer;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [4:0]      req_rd;
    logic            req_rd_we;
    logic [XLEN-1:0] req_wr_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rs1_data;
    logic [XLEN-1:0] rsp_rs2_data;
    logic            rf_cs;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic [XLEN-1:0] rf_rd_data;

    logic [XLEN-1:0] regs [32];
    logic            x0_written = 1'b0;
    int              checks = 0;
    int              errors = 0;

    regfile_access_sequencer #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rd       (req_rd),
        .req_rd_we    (req_rd_we),
        .req_wr_data  (req_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rs1_data (rsp_rs1_data),
        .rsp_rs2_data (rsp_rs2_data),
        .rf_cs        (rf_cs),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_data   (rf_rd_data)
    );

    always #5 clk = ~clk;

    // x0 is hardwired to zero; any attempted write to it is flagged.
    assign rf_rd_data = (rf_addr == 5'd0) ? '0 : regs[rf_addr];

    always @(posedge clk) begin
        if (rf_cs && rf_we) begin
            regs[rf_addr] <= rf_wr_data;
            if (rf_addr == 5'd0) x0_written <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                               input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accepting edge, then scrambles the
    // request fields so any late sampling by the DUT shows up in the results.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic we,
                                 input logic [XLEN-1:0] data);
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_rd      = rd;
        req_rd_we   = we;
        req_wr_data = data;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
        req_rs1     = 5'd31;
        req_rs2     = 5'd30;
        req_rd      = 5'd29;
        req_rd_we   = 1'b1;
        req_wr_data = 64'hDEAD;
    endtask

    task automatic runTxn(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we,
                          input logic [XLEN-1:0] data);
        applyStimulus(rs1, rs2, rd, we, data);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        checkOutput("txn_done", rsp_valid, 1);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_rs1     = 5'd0;
        req_rs2     = 5'd0;
        req_rd      = 5'd0;
        req_rd_we   = 1'b0;
        req_wr_data = '0;
        rsp_ready   = 1'b1;
        #2;
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rf_cs", rf_cs, 0);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_rf_addr", rf_addr, 0);
        checkOutput("rst_rf_wr_data", rf_wr_data, 0);
        checkOutput("rst_rsp_rs1", rsp_rs1_data, 0);
        checkOutput("rst_rsp_rs2", rsp_rs2_data, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_req_ready", req_ready, 1);

        // Preload x5, x6, x9 through the sequencer itself.
        runTxn(5'd0, 5'd0, 5'd5, 1'b1, 64'h11);
        runTxn(5'd0, 5'd0, 5'd6, 1'b1, 64'h22);
        runTxn(5'd0, 5'd0, 5'd9, 1'b1, 64'h55);
        checkOutput("preload_x5", regs[5], 64'h11);

        // Two reads plus write: RD1 x5, RD2 x6, WR x7, response after 3 cycles.
        applyStimulus(5'd5, 5'd6, 5'd7, 1'b1, 64'hAA);
        checkOutput("t1_rd1_cs", rf_cs, 1);
        checkOutput("t1_rd1_we", rf_we, 0);
        checkOutput("t1_rd1_addr", rf_addr, 5);
        checkOutput("t1_rd1_ready", req_ready, 0);
        tick();
        checkOutput("t1_rd2_addr", rf_addr, 6);
        checkOutput("t1_rd2_we", rf_we, 0);
        checkOutput("t1_rd2_valid", rsp_valid, 0);
        tick();
        checkOutput("t1_wr_we", rf_we, 1);
        checkOutput("t1_wr_addr", rf_addr, 7);
        checkOutput("t1_wr_data", rf_wr_data, 64'hAA);
        tick();
        checkOutput("t1_rsp_valid", rsp_valid, 1);
        checkOutput("t1_rsp_rs1", rsp_rs1_data, 64'h11);
        checkOutput("t1_rsp_rs2", rsp_rs2_data, 64'h22);
        checkOutput("t1_rsp_cs", rf_cs, 0);
        checkOutput("t1_rsp_addr", rf_addr, 0);
        tick();
        checkOutput("t1_idle_valid", rsp_valid, 0);
        checkOutput("t1_idle_ready", req_ready, 1);
        checkOutput("t1_x7", regs[7], 64'hAA);

        // Same source, no write: one read cycle, response after 1 cycle.
        applyStimulus(5'd5, 5'd5, 5'd3, 1'b0, 64'h0);
        checkOutput("t2_rd1_addr", rf_addr, 5);
        checkOutput("t2_rd1_we", rf_we, 0);
        tick();
        checkOutput("t2_rsp_valid", rsp_valid, 1);
        checkOutput("t2_rsp_we", rf_we, 0);
        checkOutput("t2_rsp_rs1", rsp_rs1_data, 64'h11);
        checkOutput("t2_rsp_rs2", rsp_rs2_data, 64'h11);
        tick();

        // rd equals rs1: response carries the old x5, write lands afterwards.
        runTxn(5'd5, 5'd6, 5'd5, 1'b1, 64'h99);
        checkOutput("t3_old_rs1", rsp_rs1_data, 64'h11);
        checkOutput("t3_x5_new", regs[5], 64'h99);
        applyStimulus(5'd5, 5'd0, 5'd0, 1'b0, 64'h0);
        tick();
        checkOutput("t3_lat2_not_yet", rsp_valid, 0);
        tick();
        checkOutput("t3_lat2_valid", rsp_valid, 1);
        checkOutput("t3_rd_x5", rsp_rs1_data, 64'h99);
        checkOutput("t3_rd_x0", rsp_rs2_data, 64'h0);
        tick();

        // rd = 0 with write enable: no WR cycle, x0 untouched.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 64'hFF);
        checkOutput("t4_rd1_we", rf_we, 0);
        tick();
        checkOutput("t4_rsp_valid", rsp_valid, 1);
        checkOutput("t4_rsp_we", rf_we, 0);
        checkOutput("t4_rs1_zero", rsp_rs1_data, 0);
        checkOutput("t4_rs2_zero", rsp_rs2_data, 0);
        checkOutput("t4_x0_write", x0_written, 0);
        tick();

        // One read plus write, then a stalled response with a request waiting.
        rsp_ready = 1'b0;
        applyStimulus(5'd6, 5'd6, 5'd8, 1'b1, 64'h1234);
        tick();
        checkOutput("t5_wr_addr", rf_addr, 8);
        tick();
        checkOutput("t5_lat2_valid", rsp_valid, 1);
        req_rs1   = 5'd8;
        req_rs2   = 5'd7;
        req_rd    = 5'd0;
        req_rd_we = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t5_hold_valid", rsp_valid, 1);
            checkOutput("t5_hold_rs1", rsp_rs1_data, 64'h22);
            checkOutput("t5_hold_rs2", rsp_rs2_data, 64'h22);
            checkOutput("t5_hold_ready", req_ready, 0);
            checkOutput("t5_hold_cs", rf_cs, 0);
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("t5_rel_ready", req_ready, 1);
        checkOutput("t5_rel_valid", rsp_valid, 0);
        checkOutput("t5_x8", regs[8], 64'h1234);
        tick();
        req_valid = 1'b0;
        checkOutput("t5_b2b_addr", rf_addr, 8);
        checkOutput("t5_b2b_cs", rf_cs, 1);
        tick();
        checkOutput("t5_b2b_rd2", rf_addr, 7);
        tick();
        checkOutput("t5_b2b_rs1", rsp_rs1_data, 64'h1234);
        checkOutput("t5_b2b_rs2", rsp_rs2_data, 64'hAA);
        tick();

        // Asynchronous reset during RD2 of a write to x9.
        applyStimulus(5'd5, 5'd6, 5'd9, 1'b1, 64'h77);
        tick();
        checkOutput("t6_rd2_cs", rf_cs, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_cs", rf_cs, 0);
        checkOutput("t6_async_we", rf_we, 0);
        checkOutput("t6_async_valid", rsp_valid, 0);
        checkOutput("t6_async_addr", rf_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("t6_post_cs", rf_cs, 0);
        checkOutput("t6_post_ready", req_ready, 1);
        checkOutput("t6_x9_kept", regs[9], 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
